// File: rtl/mean_filter_pkg.sv
// Shared types and constants for the 3x3 mean-filter datapath.
// Pixels are three CH_W-bit channels packed as [23:16], [15:8], [7:0].
package mean_filter_pkg;

    localparam int CH_W       = 8;
    localparam int N_CH       = 3;
    localparam int WIN_N      = 3;
    localparam int PIX_W      = CH_W * N_CH;
    localparam int COL_W      = 10;
    localparam int SUM_W      = 12;
    localparam int PROD_W     = 24;
    localparam int DIV9_MUL   = 3641;
    localparam int DIV9_SHIFT = 15;

    typedef logic [CH_W-1:0]  chan_t;
    typedef logic [PIX_W-1:0] pixel_t;

    typedef struct packed {
        pixel_t top;
        pixel_t mid;
        pixel_t bot;
    } column_t;

    typedef struct packed {
        logic eol;
        logic sof;
        logic eof;
    } flags_t;

    function automatic chan_t ch_get(pixel_t p, int unsigned c);
        return p[c*CH_W +: CH_W];
    endfunction

endpackage

// File: rtl/mean3x3_channel.sv
// One colour channel of the 3x3 mean: column sums, window sum,
// then floor(sum/9) via multiply-shift, registered into mean.
module mean3x3_channel
    import mean_filter_pkg::*;
(
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   load_col,
    input  logic                                   load_mean,
    input  logic [WIN_N-1:0][WIN_N-1:0][CH_W-1:0]  win,
    output chan_t                                  mean
);

    logic [COL_W-1:0]  col_sum [WIN_N];
    logic [SUM_W-1:0]  win_sum;
    logic [PROD_W-1:0] prod;
    chan_t             mean_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WIN_N; i++) begin
                col_sum[i] <= '0;
            end
            mean <= '0;
        end else begin
            if (load_col) begin
                for (int i = 0; i < WIN_N; i++) begin
                    col_sum[i] <= COL_W'(win[i][0])
                                + COL_W'(win[i][1])
                                + COL_W'(win[i][2]);
                end
            end
            if (load_mean) begin
                mean <= mean_next;
            end
        end
    end

    // 3641/2^15 is exact for floor(s/9) across 0..2295
    always_comb begin
        win_sum = SUM_W'(col_sum[0])
                + SUM_W'(col_sum[1])
                + SUM_W'(col_sum[2]);
        prod      = PROD_W'(win_sum) * PROD_W'(DIV9_MUL);
        mean_next = CH_W'(prod >> DIV9_SHIFT);
    end

endmodule

// File: rtl/mean_window_3x3.sv
// Builds a horizontally zero-padded 3x3 window from the three-row
// column stream and emits the per-channel mean in raster order.
module mean_window_3x3
    import mean_filter_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic [10:0]      img_width,
    input  logic [9:0]       img_height,
    input  logic             valid_i,
    input  logic [PIX_W-1:0] prev_line_data_i,
    input  logic [PIX_W-1:0] cur_line_data_i,
    input  logic [PIX_W-1:0] next_line_data_i,
    output logic             valid_o,
    output logic [PIX_W-1:0] data_o,
    output logic             eol_o,
    output logic             sof_o,
    output logic             eof_o
);

    logic [10:0] col_cnt;
    logic [9:0]  row_cnt;
    column_t     slot_l, slot_c, slot_r;
    logic        flush_pend;
    logic        flush_last_row;

    logic        col_last, row_last;
    logic        emit_a, emit;
    column_t     in_col;
    column_t     win_next [WIN_N];
    flags_t      flg_next;

    column_t     win_q [WIN_N];
    logic        win_vld, sum_vld;
    flags_t      flg1, flg2;
    chan_t       mean_ch [N_CH];

    always_comb begin
        col_last = (col_cnt == img_width - 11'd1);
        row_last = (row_cnt == img_height - 10'd1);
        in_col   = {prev_line_data_i, cur_line_data_i, next_line_data_i};
        emit_a   = valid_i && (col_cnt != 11'd0);
        emit     = emit_a || flush_pend;

        // A flush never coincides with emit_a: the column accepted
        // alongside a flush is always column 0.
        win_next[0] = slot_c;
        win_next[1] = slot_r;
        win_next[2] = flush_pend ? column_t'('0) : in_col;

        flg_next.eol = flush_pend;
        flg_next.sof = emit_a && (col_cnt == 11'd1)
                       && (row_cnt == 10'd0);
        flg_next.eof = flush_pend && flush_last_row;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_cnt        <= '0;
            row_cnt        <= '0;
            slot_l         <= '0;
            slot_c         <= '0;
            slot_r         <= '0;
            flush_pend     <= 1'b0;
            flush_last_row <= 1'b0;
        end else begin
            flush_pend <= valid_i && col_last;
            if (valid_i) begin
                if (col_cnt == 11'd0) begin
                    slot_l <= '0;
                    slot_c <= '0;
                end else begin
                    slot_l <= slot_c;
                    slot_c <= slot_r;
                end
                slot_r <= in_col;
                if (col_last) begin
                    col_cnt        <= '0;
                    row_cnt        <= row_last ? 10'd0
                                               : row_cnt + 10'd1;
                    flush_last_row <= row_last;
                end else begin
                    col_cnt <= col_cnt + 11'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < WIN_N; i++) begin
                win_q[i] <= '0;
            end
            win_vld <= 1'b0;
            sum_vld <= 1'b0;
            valid_o <= 1'b0;
            flg1    <= '0;
            flg2    <= '0;
            eol_o   <= 1'b0;
            sof_o   <= 1'b0;
            eof_o   <= 1'b0;
        end else begin
            win_vld <= emit;
            sum_vld <= win_vld;
            valid_o <= sum_vld;
            if (emit) begin
                for (int i = 0; i < WIN_N; i++) begin
                    win_q[i] <= win_next[i];
                end
                flg1 <= flg_next;
            end
            if (win_vld) begin
                flg2 <= flg1;
            end
            if (sum_vld) begin
                eol_o <= flg2.eol;
                sof_o <= flg2.sof;
                eof_o <= flg2.eof;
            end
        end
    end

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [WIN_N-1:0][WIN_N-1:0][CH_W-1:0] ch_win;

        always_comb begin
            for (int i = 0; i < WIN_N; i++) begin
                ch_win[i][0] = ch_get(win_q[i].top, c);
                ch_win[i][1] = ch_get(win_q[i].mid, c);
                ch_win[i][2] = ch_get(win_q[i].bot, c);
            end
        end

        mean3x3_channel u_ch (
            .clk       (clk),
            .reset     (reset),
            .load_col  (win_vld),
            .load_mean (sum_vld),
            .win       (ch_win),
            .mean      (mean_ch[c])
        );
    end

    assign data_o = {mean_ch[2], mean_ch[1], mean_ch[0]};

endmodule

// File: tb/tb_mean_window_3x3.sv
// Directed and reference-model checks for mean_window_3x3.
module tb_mean_window_3x3;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] img_width;
    logic [9:0]  img_height;
    logic        valid_i;
    logic [23:0] prev_line_data_i;
    logic [23:0] cur_line_data_i;
    logic [23:0] next_line_data_i;
    logic        valid_o;
    logic [23:0] data_o;
    logic        eol_o, sof_o, eof_o;

    always #5 clk = ~clk;

    mean_window_3x3 dut (
        .clk              (clk),
        .reset            (reset),
        .img_width        (img_width),
        .img_height       (img_height),
        .valid_i          (valid_i),
        .prev_line_data_i (prev_line_data_i),
        .cur_line_data_i  (cur_line_data_i),
        .next_line_data_i (next_line_data_i),
        .valid_o          (valid_o),
        .data_o           (data_o),
        .eol_o            (eol_o),
        .sof_o            (sof_o),
        .eof_o            (eof_o)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int ncyc         = 0;

    logic [23:0] out_data [$];
    logic [2:0]  out_flg  [$];
    int          out_cyc  [$];
    int          in_cyc   [$];

    always @(negedge clk) begin
        ncyc++;
        if (valid_i) in_cyc.push_back(ncyc);
        if (valid_o) begin
            out_data.push_back(data_o);
            out_flg.push_back({eol_o, sof_o, eof_o});
            out_cyc.push_back(ncyc);
        end
    end

    task automatic clear_q();
        out_data.delete();
        out_flg.delete();
        out_cyc.delete();
        in_cyc.delete();
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [23:0] p, c, n);
        prev_line_data_i = p;
        cur_line_data_i  = c;
        next_line_data_i = n;
        valid_i = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        idle(2);
        @(negedge clk);
        tests_run++;
        if ({valid_o, data_o, eol_o, sof_o, eof_o} !== 28'd0) begin
            tests_failed++;
            $display("FAIL reset_state: got v=%b d=%h f=%b%b%b want 0",
                     valid_o, data_o, eol_o, sof_o, eof_o);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_uniform();
        logic [23:0] e;
        logic [2:0]  ef;
        img_width = 11'd4;
        img_height = 10'd3;
        clear_q();
        for (int i = 0; i < 12; i++)
            drive(24'h808080, 24'h808080, 24'h808080);
        idle(8);
        tests_run++;
        if (out_data.size() != 12) begin
            tests_failed++;
            $display("FAIL uniform_count: got %0d want 12",
                     out_data.size());
        end
        for (int i = 0; i < 12 && i < out_data.size(); i++) begin
            e  = (i % 4 == 0 || i % 4 == 3) ? 24'h555555 : 24'h808080;
            ef = {i % 4 == 3, i == 0, i == 11};
            tests_run++;
            if (out_data[i] !== e || out_flg[i] !== ef) begin
                tests_failed++;
                $display("FAIL uniform[%0d]: got %h/%b want %h/%b",
                         i, out_data[i], out_flg[i], e, ef);
            end
        end
    endtask

    task automatic test_full_scale();
        logic [23:0] e;
        img_width = 11'd5;
        img_height = 10'd2;
        clear_q();
        for (int i = 0; i < 10; i++)
            drive(24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF);
        idle(8);
        tests_run++;
        if (out_data.size() != 10) begin
            tests_failed++;
            $display("FAIL full_count: got %0d want 10",
                     out_data.size());
        end
        for (int i = 0; i < 10 && i < out_data.size(); i++) begin
            e = (i % 5 == 0 || i % 5 == 4) ? 24'hAAAAAA : 24'hFFFFFF;
            tests_run++;
            if (out_data[i] !== e) begin
                tests_failed++;
                $display("FAIL full[%0d]: got %h want %h",
                         i, out_data[i], e);
            end
        end
    endtask

    task automatic test_w2();
        logic [2:0] ef;
        img_width = 11'd2;
        img_height = 10'd3;
        clear_q();
        for (int i = 0; i < 6; i++)
            drive(24'h102030, 24'h102030, 24'h102030);
        idle(8);
        tests_run++;
        if (out_data.size() != 6 || in_cyc.size() != 6) begin
            tests_failed++;
            $display("FAIL w2_count: got %0d outs %0d ins want 6",
                     out_data.size(), in_cyc.size());
        end
        for (int i = 0; i < 6 && i < out_data.size()
                        && in_cyc.size() == 6; i++) begin
            ef = {i % 2 == 1, i == 0, i == 5};
            tests_run++;
            if (out_data[i] !== 24'h0A1520 || out_flg[i] !== ef) begin
                tests_failed++;
                $display("FAIL w2[%0d]: got %h/%b want 0a1520/%b",
                         i, out_data[i], out_flg[i], ef);
            end
            tests_run++;
            if (out_cyc[i] != in_cyc[(i/2)*2+1] + 3 + (i % 2)) begin
                tests_failed++;
                $display("FAIL w2_time[%0d]: got %0d want %0d", i,
                         out_cyc[i], in_cyc[(i/2)*2+1] + 3 + (i % 2));
            end
        end
    endtask

    task automatic test_idle_gap();
        logic [23:0] col_v [4];
        logic [23:0] e [4];
        col_v = '{24'h090909, 24'h121212, 24'h1B1B1B, 24'h242424};
        e     = '{24'h090909, 24'h121212, 24'h1B1B1B, 24'h151515};
        img_width = 11'd4;
        img_height = 10'd1;
        clear_q();
        for (int i = 0; i < 4; i++)
            drive(col_v[i], col_v[i], col_v[i]);
        idle(6);
        tests_run++;
        if (out_data.size() != 4 || in_cyc.size() != 4) begin
            tests_failed++;
            $display("FAIL gap_count: got %0d want 4", out_data.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                tests_run++;
                if (out_data[i] !== e[i]) begin
                    tests_failed++;
                    $display("FAIL gap[%0d]: got %h want %h",
                             i, out_data[i], e[i]);
                end
            end
            tests_run++;
            if (out_cyc[3] != in_cyc[3] + 4) begin
                tests_failed++;
                $display("FAIL gap_time: got %0d want %0d",
                         out_cyc[3], in_cyc[3] + 4);
            end
            tests_run++;
            if (out_flg[0] !== 3'b010 || out_flg[3] !== 3'b101) begin
                tests_failed++;
                $display("FAIL gap_flags: got %b %b want 010 101",
                         out_flg[0], out_flg[3]);
            end
        end
    endtask

    task automatic test_random();
        localparam int W = 17;
        localparam int H = 9;
        localparam int FR = 40;
        logic [23:0] pr [W];
        logic [23:0] cu [W];
        logic [23:0] nx [W];
        logic [23:0] exp_d [$];
        logic [2:0]  exp_f [$];
        logic [23:0] e;
        int s, xx;
        img_width = 11'(W);
        img_height = 10'(H);
        clear_q();
        for (int f = 0; f < FR; f++) begin
            for (int r = 0; r < H; r++) begin
                for (int x = 0; x < W; x++) begin
                    pr[x] = 24'($urandom);
                    cu[x] = 24'($urandom);
                    nx[x] = 24'($urandom);
                end
                for (int x = 0; x < W; x++) begin
                    for (int ch = 0; ch < 3; ch++) begin
                        s = 0;
                        for (int dx = -1; dx <= 1; dx++) begin
                            xx = x + dx;
                            if (xx >= 0 && xx < W)
                                s += int'(pr[xx][ch*8 +: 8])
                                   + int'(cu[xx][ch*8 +: 8])
                                   + int'(nx[xx][ch*8 +: 8]);
                        end
                        e[ch*8 +: 8] = 8'(s / 9);
                    end
                    exp_d.push_back(e);
                    exp_f.push_back({x == W-1, x == 0 && r == 0,
                                     x == W-1 && r == H-1});
                end
                for (int x = 0; x < W; x++) begin
                    if ($urandom_range(0, 3) == 0)
                        idle($urandom_range(1, 3));
                    drive(pr[x], cu[x], nx[x]);
                end
            end
        end
        idle(10);
        tests_run++;
        if (out_data.size() != W * H * FR) begin
            tests_failed++;
            $display("FAIL rand_count: got %0d want %0d",
                     out_data.size(), W * H * FR);
        end
        for (int i = 0; i < exp_d.size() && i < out_data.size(); i++) begin
            tests_run++;
            if (out_data[i] !== exp_d[i] || out_flg[i] !== exp_f[i]) begin
                tests_failed++;
                $display("FAIL rand[%0d]: got %h/%b want %h/%b", i,
                         out_data[i], out_flg[i], exp_d[i], exp_f[i]);
            end
        end
    endtask

    task automatic test_reset_midline();
        img_width = 11'd4;
        img_height = 10'd2;
        clear_q();
        for (int i = 0; i < 3; i++)
            drive(24'h808080, 24'h808080, 24'h808080);
        reset = 1'b1;
        idle(1);
        reset = 1'b0;
        idle(6);
        tests_run++;
        if (out_data.size() != 0) begin
            tests_failed++;
            $display("FAIL rst_inflight: got %0d outputs want 0",
                     out_data.size());
        end
        img_height = 10'd1;
        clear_q();
        for (int i = 0; i < 4; i++)
            drive(24'h808080, 24'h808080, 24'h808080);
        idle(8);
        tests_run++;
        if (out_data.size() != 4) begin
            tests_failed++;
            $display("FAIL rst_count: got %0d want 4", out_data.size());
        end else begin
            tests_run++;
            if (out_flg[0] !== 3'b010 || out_data[0] !== 24'h555555) begin
                tests_failed++;
                $display("FAIL rst_first: got %h/%b want 555555/010",
                         out_data[0], out_flg[0]);
            end
            tests_run++;
            if (out_flg[3] !== 3'b101 || out_data[3] !== 24'h555555) begin
                tests_failed++;
                $display("FAIL rst_last: got %h/%b want 555555/101",
                         out_data[3], out_flg[3]);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        valid_i = 1'b0;
        prev_line_data_i = '0;
        cur_line_data_i = '0;
        next_line_data_i = '0;
        img_width = 11'd4;
        img_height = 10'd3;
        test_reset();
        test_uniform();
        test_full_scale();
        test_w2();
        test_idle_gap();
        test_random();
        test_reset_midline();
        $display("[TB] %0d tests run, %0d failed",
                 tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/mean_window_3x3.md
# mean_window_3x3

Consumes the three-row column stream from the image line buffer: previous, current and next line pixels, all for the same column. Forms a 3x3 window per pixel with zero-padding at the left and right edges, then outputs the per-channel mean as a raster pixel stream. It sits directly after the line buffer in the mean-filter datapath. Vertical borders arrive already zeroed from upstream and get no special treatment here.

## Interface
- `CH_W`, 8, bits per colour channel; a pixel is three channels, 24 bits.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `img_width`  in  11  pixels per line. Legal range 2..2047. Static within a frame.
- `img_height`  in  10  lines per frame. Legal range 1..1023. Static within a frame.
- `valid_i`  in  1  one column of three pixels is present this cycle.
- `prev_line_data_i`  in  24  pixel from row r-1 (top of window).
- `cur_line_data_i`  in  24  pixel from row r (centre).
- `next_line_data_i`  in  24  pixel from row r+1 (bottom).
- `valid_o`  out  1  `data_o` holds a filtered pixel.
- `data_o`  out  24  mean pixel, channels at [23:16], [15:8], [7:0].
- `eol_o`  out  1  qualifies the last pixel of a line.
- `sof_o`  out  1  qualifies the first pixel of a frame.
- `eof_o`  out  1  qualifies the last pixel of a frame.

## Operation
- **Input counters**
  - `col_cnt` (11 b) advances on each `valid_i` and wraps at `img_width`-1.
  - `row_cnt` (10 b) advances when a column at `img_width`-1 is accepted, and wraps at `img_height`-1.
- **Column shift register**
  - Three column slots: L, C, R. Each slot holds three pixels.
  - On `valid_i` the slots shift L<-C, C<-R, R<-input.
  - On accepting column 0, slots L and C load zero. This is the left pad.
- **Emit events.** Each event produces exactly one output pixel.
  - (a) Accepting column x+1, for x in 0..W-2, emits pixel x. The window is the shifted L/C/R.
  - (b) The cycle after column W-1 is accepted, pixel W-1 is emitted unconditionally. The window is L<-C, C<-R, R<-0, which is the right pad.
  - Accepting column 0 never emits. So a flush (b) coinciding with a column-0 arrival from the next line has no conflict; both are processed in the same cycle.
- **Arithmetic, per channel**
  - Column sum: 3 x 8 b -> 10 b.
  - Window sum: 3 x 10 b -> 12 b, maximum 2295.
  - Mean = floor(sum/9), computed as (sum * 3641) >> 15 with a 24 b product.
  - This is exact for every sum in 0..2295 and saturation-free.
- **Output flags**
  - `eol_o`: the emitted pixel is x = W-1.
  - `sof_o`: x = 0 and row 0.
  - `eof_o`: x = W-1 and row H-1.
  - Flags travel in the pipeline alongside the data.
- Gaps in `valid_i` anywhere are legal. The window state holds, and no output is produced except the pending flush (b).

## Timing
- Reset values: `valid_o`, `data_o`, `eol_o`, `sof_o`, `eof_o`, all counters, slots and the flush-pending flag are 0.
- Latency: for an emit event in cycle E, `valid_o` = 1 in cycle E+3.
  - Pipeline stages: window registers at E+1, column sums at E+2, window sum with divide registered into `data_o` at E+3.
- Throughput: one pixel per cycle sustained. Output order is strictly raster.
- `data_o` and the flags hold their last value when `valid_o` = 0. Do not rely on these held values.
- Reset in the middle of a frame: everything returns to reset values on the next edge. In-flight pixels and a pending flush are discarded. The next accepted column is treated as column 0, row 0.
- `img_width` = 2: every accepted column 1 is followed by a flush. Back-to-back lines yield exactly 2 outputs per line.
- `img_height` = 1: every pixel asserts both `sof_o`/`eof_o` rules as applicable.

## Structure
- Shared package `mean_filter_pkg` holds:
  - `CH_W` = 8, `WIN_N` = 3.
  - `SUM_W` = 12.
  - `DIV9_MUL` = 3641, `DIV9_SHIFT` = 15.
  - The 24-bit pixel typedef, with channel slice helpers.
- Sub-module `mean3x3_channel`: column sums, window sum and the multiply-shift divide for one channel. Instantiate it three times.
- The top level owns the counters, shift slots, emit/flush control and the flag pipeline.

## Test plan
- **Uniform mid-grey.** W=4, H=3, all three line inputs constant 0x808080, back-to-back.
  - Per line: outputs 0x555555, 0x808080, 0x808080, 0x555555.
  - 12 outputs in total. `eol_o` on every 4th output; `sof_o` on the 1st, `eof_o` on the 12th.
- **Full scale.** All inputs 0xFFFFFF, W=5: interior pixels 0xFFFFFF, edge pixels 0xAAAAAA (1530/9 = 170).
- **Random windows.** 10k cycles of random pixels with W=17, H=9 and random `valid_i` gaps.
  - Every `data_o` channel equals floor(window sum / 9) from a zero-padded reference model.
  - Output count equals W*H.
- **W=2, continuous input.** Each flush coincides with the next line's column 0.
  - Exactly 2 outputs per line, none dropped.
  - `valid_o` timing: column 1 accepted at t gives outputs at t+3 and t+4.
- **Idle gap at line end.** `valid_i` is low for 6 cycles after column W-1: the last pixel still appears 4 cycles after column W-1 is accepted.
- **Reset mid-line.** Reset is pulsed with 2 pixels in flight.
  - No further `valid_o` is produced.
  - The following stimulus starts a fresh frame with `sof_o` on its first output.
